// File: rtl/mux2to1_arbiter.sv
// Two-requester round-robin arbiter driving the registered select of a 2:1 data mux.
// Define MUX2TO1_ARB_TIMEOUT_EN to build the hold counter that forces hand-over after MAX_HOLD cycles.
module mux2to1_arbiter #(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] w0,
    input  logic [WIDTH-1:0] w1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             S,
    output logic [WIDTH-1:0] f
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   last_q,  last_d;
    logic   gnt0_q,  gnt0_d;
    logic   gnt1_q,  gnt1_d;
    logic   s_q,     s_d;

`ifdef MUX2TO1_ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [7:0] hold_q, hold_d;
    logic       hold_expired;

    assign hold_expired = (hold_q == HOLD_LAST);
`else
    logic hold_expired;

    assign hold_expired = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                // On a tie the requester that did not own the mux last wins.
                if (req0 && req1)
                    state_d = last_q ? OWN0 : OWN1;
                else if (req0)
                    state_d = OWN0;
                else if (req1)
                    state_d = OWN1;
            end
            OWN0: begin
                if (!req0)
                    state_d = req1 ? OWN1 : IDLE;
                else if (req1 && hold_expired)
                    state_d = OWN1;
            end
            OWN1: begin
                if (!req1)
                    state_d = req0 ? OWN0 : IDLE;
                else if (req0 && hold_expired)
                    state_d = OWN0;
            end
            default: state_d = IDLE;
        endcase

        last_d = last_q;
        if (state_d == OWN0)
            last_d = 1'b0;
        else if (state_d == OWN1)
            last_d = 1'b1;

        gnt0_d = (state_d == OWN0);
        gnt1_d = (state_d == OWN1);

        // Select holds its last value while idle so the consumer sees a stable word.
        s_d = s_q;
        if (state_d == OWN0)
            s_d = 1'b0;
        else if (state_d == OWN1)
            s_d = 1'b1;
    end

`ifdef MUX2TO1_ARB_TIMEOUT_EN
    always_comb begin
        hold_d = 8'd0;
        if ((state_d == state_q) && (state_q != IDLE))
            hold_d = hold_expired ? hold_q : hold_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            hold_q <= 8'd0;
        else
            hold_q <= hold_d;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            s_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            s_q     <= s_d;
        end
    end

    assign gnt0 = gnt0_q;
    assign gnt1 = gnt1_q;
    assign S    = s_q;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_f_bit
            assign f[gi] = s_q ? w1[gi] : w0[gi];
        end
    endgenerate

endmodule

// File: tb/tb_mux2to1_arbiter.sv
// Self-checking bench for mux2to1_arbiter: vector table through a scoreboard queue,
// plus hand-written sequences for asynchronous reset and the hold/timeout behaviour.
module tb_mux2to1_arbiter;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             req0;
    logic             req1;
    logic [WIDTH-1:0] w0;
    logic [WIDTH-1:0] w1;
    logic             gnt0;
    logic             gnt1;
    logic             S;
    logic [WIDTH-1:0] f;

    mux2to1_arbiter #(
        .WIDTH    (WIDTH),
        .MAX_HOLD (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req0  (req0),
        .req1  (req1),
        .w0    (w0),
        .w1    (w1),
        .gnt0  (gnt0),
        .gnt1  (gnt1),
        .S     (S),
        .f     (f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             r0;
        logic             r1;
        logic [WIDTH-1:0] d0;
        logic [WIDTH-1:0] d1;
        logic             g0;
        logic             g1;
        logic             s;
    } vec_t;

    typedef struct {
        logic             g0;
        logic             g1;
        logic             s;
        logic [WIDTH-1:0] f;
    } exp_t;

    exp_t sb_q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   step_no = 0;

    function automatic vec_t mk(logic r0, logic r1, logic [WIDTH-1:0] d0, logic [WIDTH-1:0] d1,
                                logic g0, logic g1, logic s);
        vec_t v;
        v.r0 = r0; v.r1 = r1; v.d0 = d0; v.d1 = d1;
        v.g0 = g0; v.g1 = g1; v.s = s;
        return v;
    endfunction

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s (step %0d): got %h, expected %h", name, step_no, act, exp);
    endtask

    // Drive one vector, queue its expected outputs, clock once, then pop and compare.
    task automatic step(input vec_t v);
        exp_t e;
        exp_t got;
        req0 = v.r0; req1 = v.r1; w0 = v.d0; w1 = v.d1;
        e.g0 = v.g0; e.g1 = v.g1; e.s = v.s;
        e.f  = v.s ? v.d1 : v.d0;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        step_no++;
        got = sb_q.pop_front();
        check("gnt0", {7'd0, gnt0}, {7'd0, got.g0});
        check("gnt1", {7'd0, gnt1}, {7'd0, got.g1});
        check("S",    {7'd0, S},    {7'd0, got.s});
        check("f",    f,            got.f);
    endtask

    vec_t tbl[19];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        // Reset, single requester, round-robin ties and direct hand-overs.
        tbl[0]  = mk(1, 1, 8'hA5, 8'h5A, 1, 0, 0);
        tbl[1]  = mk(0, 0, 8'h12, 8'h34, 0, 0, 0);
        tbl[2]  = mk(0, 1, 8'h01, 8'h3C, 0, 1, 1);
        tbl[3]  = mk(0, 1, 8'h02, 8'h3C, 0, 1, 1);
        tbl[4]  = mk(0, 1, 8'h03, 8'h3C, 0, 1, 1);
        tbl[5]  = mk(0, 0, 8'h11, 8'h3C, 0, 0, 1);
        tbl[6]  = mk(0, 0, 8'h22, 8'h77, 0, 0, 1);
        tbl[7]  = mk(1, 1, 8'hC3, 8'h96, 1, 0, 0);
        tbl[8]  = mk(1, 1, 8'hC4, 8'h97, 1, 0, 0);
        tbl[9]  = mk(0, 1, 8'hC5, 8'h98, 0, 1, 1);
        tbl[10] = mk(1, 1, 8'hC6, 8'h99, 0, 1, 1);
        tbl[11] = mk(1, 0, 8'hC7, 8'h9A, 1, 0, 0);
        tbl[12] = mk(1, 1, 8'hC8, 8'h9B, 1, 0, 0);
        tbl[13] = mk(0, 1, 8'hC9, 8'h9C, 0, 1, 1);
        tbl[14] = mk(1, 1, 8'hCA, 8'h9D, 0, 1, 1);
        tbl[15] = mk(1, 0, 8'hCB, 8'h9E, 1, 0, 0);
        tbl[16] = mk(0, 0, 8'hCC, 8'h9F, 0, 0, 0);
        tbl[17] = mk(1, 1, 8'hF0, 8'h0F, 0, 1, 1);
        tbl[18] = mk(0, 0, 8'hE1, 8'h1E, 0, 0, 1);

        rst_n = 1'b0; req0 = 1'b1; req1 = 1'b1; w0 = 8'hA5; w1 = 8'h5A;
        repeat (2) @(posedge clk);
        #1;
        check("reset_gnt0", {7'd0, gnt0}, 8'd0);
        check("reset_gnt1", {7'd0, gnt1}, 8'd0);
        check("reset_S",    {7'd0, S},    8'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++)
            step(tbl[i]);

        // Asynchronous reset while requester 1 owns the mux.
        step(mk(0, 1, 8'h44, 8'h88, 0, 1, 1));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_gnt1", {7'd0, gnt1}, 8'd0);
        check("async_rst_gnt0", {7'd0, gnt0}, 8'd0);
        check("async_rst_S",    {7'd0, S},    8'd0);
        req0 = 1'b1; req1 = 1'b1;
        @(posedge clk);
        #1;
        check("held_rst_gnt0", {7'd0, gnt0}, 8'd0);
        check("held_rst_gnt1", {7'd0, gnt1}, 8'd0);
        #2;
        rst_n = 1'b1;
        step(mk(1, 1, 8'h5C, 8'hC5, 1, 0, 0));
        step(mk(0, 0, 8'h5D, 8'hD5, 0, 0, 0));

        // Requester 0 granted, requester 1 raised as the grant first appears.
        step(mk(1, 0, 8'h61, 8'h16, 1, 0, 0));
`ifdef MUX2TO1_ARB_TIMEOUT_EN
        for (int k = 0; k < 3; k++)
            step(mk(1, 1, 8'h70 + 8'(k), 8'h07, 1, 0, 0));
        step(mk(1, 1, 8'h80, 8'h08, 0, 1, 1));
        for (int k = 0; k < 3; k++)
            step(mk(1, 1, 8'h90, 8'h09 + 8'(k), 0, 1, 1));
        step(mk(1, 1, 8'hA0, 8'h0A, 1, 0, 0));
`else
        for (int k = 0; k < 50; k++)
            step(mk(1, 1, 8'(k), 8'hFF - 8'(k), 1, 0, 0));
`endif
        step(mk(0, 0, 8'hB0, 8'h0B, 0, 0, 0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
